// File: rtl/rvscc_pkg.sv
// Shared store-buffer types: entry record and DEPTH-derived pointer width.
package rvscc_pkg;

  localparam int SB_N     = 32;
  localparam int SB_DEPTH = 4;

  function automatic int sb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int SB_PTR_W = sb_ptr_w(SB_DEPTH);

  typedef struct packed {
    logic [SB_N-1:0] addr;
    logic [SB_N-1:0] data;
    logic            valid;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match search over buffered word addresses, scanning oldest to youngest from head.
module store_buffer_match
  import rvscc_pkg::*;
#(
  parameter int W     = SB_N - 2,
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = sb_ptr_w(DEPTH)
) (
  input  logic [DEPTH-1:0]        valid_i,
  input  logic [DEPTH-1:0][W-1:0] addr_i,
  input  logic [PW-1:0]           head_i,
  input  logic [W-1:0]            ld_addr_i,
  output logic                    hit_o,
  output logic [PW-1:0]           idx_o
);

  logic [PW-1:0] idx;

  // Later (younger) matches overwrite earlier ones.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (valid_i[idx] && (addr_i[idx] == ld_addr_i)) begin
        hit_o = 1'b1;
        idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Word store buffer with in-order drain; store-to-load forwarding when STORE_BUFFER_FWD_EN is defined,
// otherwise loads stall until the buffer is empty.
module store_buffer
  import rvscc_pkg::*;
#(
  parameter int N     = SB_N,
  parameter int DEPTH = SB_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [N-1:0] st_addr,
  input  logic [N-1:0] st_data,
  input  logic         ld_valid,
  input  logic [N-1:0] ld_addr,
  output logic         ld_ready,
  output logic [N-1:0] ld_data,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_write_data,
  output logic         mem_write_enable,
  input  logic [N-1:0] mem_read_data,
  output logic         empty
);

  localparam int PW = sb_ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  sb_entry_t [DEPTH-1:0]       ent_q, ent_d;

  logic full, empty_w, enq, load_go, drain;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty_w  = (cnt_q == '0);
  assign st_ready = !full;
  assign empty    = empty_w;
  assign enq      = st_valid && !full;
  assign load_go  = ld_valid && ld_ready;
  assign drain    = !empty_w && ent_q[head_q].valid && !load_go;

`ifdef STORE_BUFFER_FWD_EN
  logic [DEPTH-1:0]        vld_vec;
  logic [DEPTH-1:0][N-3:0] wa_vec;
  logic                    hit;
  logic [PW-1:0]           hit_idx;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld_vec[i] = ent_q[i].valid;
      wa_vec[i]  = ent_q[i].addr[N-1:2];
    end
  end

  store_buffer_match #(
    .W     (N - 2),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_match (
    .valid_i   (vld_vec),
    .addr_i    (wa_vec),
    .head_i    (head_q),
    .ld_addr_i (ld_addr[N-1:2]),
    .hit_o     (hit),
    .idx_o     (hit_idx)
  );

  assign ld_ready = 1'b1;
  assign ld_data  = hit ? ent_q[hit_idx].data : mem_read_data;
`else
  assign ld_ready = empty_w;
  assign ld_data  = mem_read_data;
`endif

  always_comb begin
    mem_addr         = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    if (load_go) begin
      mem_addr = ld_addr;
    end else if (drain) begin
      mem_addr         = ent_q[head_q].addr;
      mem_write_data   = ent_q[head_q].data;
      mem_write_enable = 1'b1;
    end
  end

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (drain) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + PW'(1);
    end
    if (enq) begin
      ent_d[tail_q].addr  = st_addr;
      ent_d[tail_q].data  = st_data;
      ent_d[tail_q].valid = 1'b1;
      tail_d              = tail_q + PW'(1);
    end
    unique case ({enq, drain})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Reset drops every pending store; nothing issues afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ent_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ent_q  <= ent_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer; memory writes checked against a queue of accepted stores.
module tb_store_buffer;

  localparam int N     = 32;
  localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FWD_EN
  localparam int PEND = 3;
`else
  localparam int PEND = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st_valid, st_ready, ld_valid, ld_ready, mem_write_enable, empty;
  logic [N-1:0] st_addr, st_data, ld_addr, ld_data, mem_addr, mem_write_data, mem_read_data;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] d;
  } wr_t;

  wr_t         sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [0:63];
  logic [31:0] dcnt;

  always #5 clk = ~clk;

  store_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .st_valid         (st_valid),
    .st_ready         (st_ready),
    .st_addr          (st_addr),
    .st_data          (st_data),
    .ld_valid         (ld_valid),
    .ld_addr          (ld_addr),
    .ld_ready         (ld_ready),
    .ld_data          (ld_data),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data),
    .empty            (empty)
  );

  assign mem_read_data = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write_enable) mem[mem_addr[7:2]] <= mem_write_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score any memory write, record an accepted store, advance past the edge.
  task automatic cyc();
    @(negedge clk);
    if (mem_write_enable) begin
      if (sbq.size() == 0) chk("sb_unexpected_write", mem_write_enable, 1'b0);
      else begin : pop
        wr_t w;
        w = sbq.pop_front();
        chk("sb_addr", mem_addr, w.a);
        chk("sb_data", mem_write_data, w.d);
      end
    end
    if (st_valid && st_ready && !rst) sbq.push_back('{st_addr, st_data});
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [N-1:0] a, input logic [N-1:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 20 && !empty; i++) cyc();
    chk("drain_done", empty, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
    st_valid = 0; st_addr = 0; st_data = 0; ld_valid = 0; ld_addr = 0;
    dcnt = 32'h1000;

    // reset state
    #12;
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_mwe", mem_write_enable, 1'b0);
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single store drains the next cycle
    store(32'h10, 32'hDEADBEEF);
    #1 chk("s1_st_ready", st_ready, 1'b1);
    cyc();
    st_valid = 0;
    #1;
    chk("s1_mwe", mem_write_enable, 1'b1);
    chk("s1_addr", mem_addr, 32'h10);
    chk("s1_data", mem_write_data, 32'hDEADBEEF);
    chk("s1_empty_pend", empty, 1'b0);
    cyc();
    chk("s1_empty_after", empty, 1'b1);
    chk("s1_idle_mwe", mem_write_enable, 1'b0);
    chk("s1_idle_addr", mem_addr, 0);
    chk("s1_idle_wdata", mem_write_data, 0);

    // load against a pending store
    store(32'h30, 32'h55);
    cyc();
    st_valid = 0; ld_valid = 1; ld_addr = 32'h30;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    chk("ld_fwd_ready", ld_ready, 1'b1);
    chk("ld_fwd_data", ld_data, 32'h55);
    chk("ld_fwd_mwe", mem_write_enable, 1'b0);
    chk("ld_fwd_addr", mem_addr, 32'h30);
    ld_valid = 0;
    drain_all();
`else
    chk("ld_stall_ready", ld_ready, 1'b0);
    chk("ld_stall_mwe", mem_write_enable, 1'b1);
    chk("ld_stall_addr", mem_addr, 32'h30);
    cyc();
    chk("ld_go_ready", ld_ready, 1'b1);
    chk("ld_go_data", ld_data, 32'h55);
    chk("ld_go_mwe", mem_write_enable, 1'b0);
    chk("ld_go_addr", mem_addr, 32'h30);
    ld_valid = 0;
`endif

    // stores under a held load
    ld_valid = 1; ld_addr = 32'h80;
`ifdef STORE_BUFFER_FWD_EN
    for (int i = 0; i < 4; i++) begin
      store(32'h40 + 4*i, 32'h100 + i);
      #1 chk("fill_st_ready", st_ready, 1'b1);
      cyc();
    end
    store(32'h50, 32'h104);
    #1;
    chk("full_st_ready", st_ready, 1'b0);
    chk("full_mwe", mem_write_enable, 1'b0);
    chk("full_empty", empty, 1'b0);
    cyc();
    chk("stall_st_ready", st_ready, 1'b0);
    ld_valid = 0;
    #1;
    chk("drain1_mwe", mem_write_enable, 1'b1);
    chk("drain1_addr", mem_addr, 32'h40);
    cyc();
    chk("reopen_st_ready", st_ready, 1'b1);
    cyc();
    st_valid = 0;
    drain_all();
`else
    for (int i = 0; i < 5; i++) begin
      store(32'h40 + 4*i, 32'h100 + i);
      #1;
      chk("flow_st_ready", st_ready, 1'b1);
      chk("flow_ld_ready", ld_ready, (i == 0));
      cyc();
    end
    st_valid = 0; ld_valid = 0;
    drain_all();
`endif

`ifdef STORE_BUFFER_FWD_EN
    // full buffer: drain frees a slot, then enqueue+drain holds at three
    ld_valid = 1;
    for (int i = 0; i < 4; i++) begin store(32'h60 + 4*i, dcnt); dcnt++; cyc(); end
    ld_valid = 0;
    store(32'hA0, dcnt);
    #1;
    chk("ed_full_ready", st_ready, 1'b0);
    chk("ed_full_mwe", mem_write_enable, 1'b1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      store(32'hA0 + 4*i, dcnt); dcnt++;
      #1;
      chk("ed_hold_ready", st_ready, 1'b1);
      chk("ed_hold_mwe", mem_write_enable, 1'b1);
      cyc();
    end
    ld_valid = 1;
    store(32'hB0, dcnt); dcnt++;
    #1 chk("ed_refill_mwe", mem_write_enable, 1'b0);
    cyc();
    chk("ed_refill_full", st_ready, 1'b0);
    st_valid = 0; ld_valid = 0;
    drain_all();
`endif

    // pointer wrap: 2*DEPTH back-to-back stores
    for (int i = 0; i < 2*DEPTH; i++) begin
      store(32'h80 + 4*i, $urandom);
      cyc();
    end
    st_valid = 0;
    drain_all();

`ifdef STORE_BUFFER_FWD_EN
    // youngest match, word-granular compare, same-cycle store excluded
    ld_valid = 1; ld_addr = 32'hC0;
    store(32'h20, 32'h1); cyc();
    store(32'h20, 32'h2); cyc();
    st_valid = 0; ld_addr = 32'h20;
    #1;
    chk("fwd_young", ld_data, 32'h2);
    chk("fwd_ready", ld_ready, 1'b1);
    ld_addr = 32'h22;
    #1 chk("fwd_lowbits", ld_data, 32'h2);
    ld_addr = 32'h24;
    #1 chk("fwd_miss", ld_data, 32'hC0DE_0009);
    ld_addr = 32'h20;
    store(32'h20, 32'h3);
    #1 chk("fwd_same_cycle", ld_data, 32'h2);
    cyc();
    st_valid = 0;
    #1 chk("fwd_after_enq", ld_data, 32'h3);
    ld_valid = 0;
    drain_all();
    ld_valid = 1;
    #1 chk("fwd_mem_final", ld_data, 32'h3);
    ld_valid = 0;
`endif

    // reset with stores pending
    ld_valid = 1;
    for (int i = 0; i < PEND; i++) begin store(32'hD0 + 4*i, 32'h700 + i); cyc(); end
    st_valid = 0; ld_valid = 0;
    #1 chk("rmid_mwe_pre", mem_write_enable, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rmid_mwe", mem_write_enable, 1'b0);
    chk("rmid_empty", empty, 1'b1);
    chk("rmid_st_ready", st_ready, 1'b1);
    sbq.delete();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rpost_mwe", mem_write_enable, 1'b0);
      chk("rpost_empty", empty, 1'b1);
      cyc();
    end

    chk("sb_leftover", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter N, default 32, meaning address/data width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of buffered stores (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port st_valid  input  1  core presents a word store.
REQ-006 SHALL have port st_ready  output  1  buffer accepts the store this cycle.
REQ-007 SHALL have ports st_addr and st_data  input  N each  store address and word.
REQ-008 SHALL have port ld_valid  input  1  core presents a word load.
REQ-009 SHALL have port ld_addr  input  N  load address.
REQ-010 SHALL have port ld_ready  output  1  load completes this cycle.
REQ-011 SHALL have port ld_data  output  N  load result, valid when ld_valid && ld_ready.
REQ-012 SHALL have ports mem_addr and mem_write_data  output  N each  data memory address and write word.
REQ-013 SHALL have port mem_write_enable  output  1  data memory write strobe.
REQ-014 SHALL have port mem_read_data  input  N  combinational read word from data memory.
REQ-015 SHALL have port empty  output  1  no pending stores (used for fences).

Function
REQ-016 SHALL hold stores in a circular FIFO: head/tail pointers mod DEPTH, count 0..DEPTH.
REQ-017 SHALL drive st_ready = (count != DEPTH); a store enqueues at tail on st_valid && st_ready.
REQ-018 SHALL compare addresses on bits [N-1:2] only; bits [1:0] are stored and forwarded unchanged to mem_addr.
REQ-019 SHALL drain: when count != 0 and ld_valid == 0, mem_addr/mem_write_data = head entry, mem_write_enable = 1, head advances at posedge.
REQ-020 SHALL give loads priority: when ld_valid == 1, mem_addr = ld_addr, mem_write_enable = 0, no drain that cycle.
REQ-021 SHALL keep count unchanged on simultaneous enqueue and drain; enqueue when full SHALL NOT occur even if a drain happens that cycle.
REQ-022 SHALL set ld_data to the data of the youngest valid entry matching ld_addr, else mem_read_data (zero-latency, combinational).
REQ-023 SHALL exclude a store being enqueued in the same cycle from load matching.
REQ-024 SHALL drive empty = (count == 0); when idle, mem_addr = 0, mem_write_data = 0, mem_write_enable = 0.
REQ-025 SHALL preserve FIFO order of memory writes exactly as accepted.

Reset
REQ-026 SHALL on rst clear head, tail, count and all entry valid bits asynchronously.
REQ-027 SHALL after reset drive st_ready = 1, empty = 1, mem_write_enable = 0, ld_ready = 1.
REQ-028 SHALL discard pending stores when reset asserts mid-operation; no partial write issues after reset.

Configuration
REQ-029 SHALL use macro STORE_BUFFER_FWD_EN to select forwarding.
REQ-030 SHALL with STORE_BUFFER_FWD_EN defined: ld_ready = 1 always, forwarding per REQ-022.
REQ-031 SHALL without it: ld_ready = (count == 0), ld_data = mem_read_data, and drain SHALL proceed while a load is stalled (REQ-020 priority applies only when ld_ready == 1).

Structure
REQ-032 SHALL place the entry typedef (addr, data, valid) and DEPTH-derived pointer width in shared package rvscc_pkg.
REQ-033 SHALL implement youngest-match address search as sub-module store_buffer_match.

Verification
REQ-034 SHALL cover: store 0x10<-0xDEADBEEF, no load -> next cycle mem_write_enable = 1, mem_addr = 0x10, mem_write_data = 0xDEADBEEF; empty = 1 after.
REQ-035 SHALL cover: 4 stores while ld_valid held high -> st_ready = 0 after the 4th; 5th store stalls; drop ld_valid -> 4 writes in order, st_ready returns to 1 after the first.
REQ-036 SHALL cover (FWD_EN): stores 0x20<-1 then 0x20<-2 pending, load 0x20 -> ld_data = 2, ld_ready = 1; load 0x24 -> ld_data = mem_read_data.
REQ-037 SHALL cover (no FWD_EN): one store pending, ld_valid = 1 -> ld_ready = 0 until drain, then ld_ready = 1 with memory value.
REQ-038 SHALL cover: full buffer, enqueue and drain same cycle -> count stays 3 then refills; pointer wrap after 2*DEPTH stores keeps order.
REQ-039 SHALL cover: rst asserted with 3 pending stores, mid-cycle -> mem_write_enable = 0 immediately, empty = 1, no further writes.
